cordic_phase_gen: RTL

- Upstream phase source for the 16-stage pipelined CORDIC sin/cos core.
- Accumulates a degree phase in Q9.16 (0 to just under 360 degrees) by a programmable step each enabled cycle.
- Converts the phase to the core's Phase format: bits[17:16] are the quadrant, bits[15:0] are the integer residual degrees 0..89, and bits[31:18] are 0.
- Delays sample-valid by the core latency so downstream logic knows when Sin/Cos are valid. Includes run/drain control and wrap detection.

---
 rtl/cordic_pkg.sv | 46 ++++
 rtl/cordic_valid_delay.sv | 37 +++
 rtl/cordic_phase_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: constants and helpers shared by the CORDIC phase front-end.
//   DEG_90 / DEG_360  : angle constants in Q9.16 degrees
//   CORDIC_LAT        : Phase-in to Sin/Cos-out latency of the CORDIC core
//   state_e           : phase generator control states
//   QUAD_MSB/QUAD_LSB : quadrant field position inside the core Phase word
//   to_phase()        : integer degrees 0..359 -> {14'b0, quadrant, residual}
package cordic_pkg;

  localparam int          CORDIC_LAT = 18;
  localparam int          FRAC_W     = 16;
  localparam logic [31:0] DEG_90     = 32'h005A_0000;
  localparam logic [31:0] DEG_360    = 32'h0168_0000;
  localparam int          QUAD_MSB   = 17;
  localparam int          QUAD_LSB   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Split an integer degree value into quadrant and residual (0..89).
  function automatic logic [31:0] to_phase(input logic [8:0] deg);
    logic [1:0]  quad;
    logic [8:0]  resid;
    logic [31:0] word;
    if (deg >= 9'd270) begin
      quad  = 2'd3;
      resid = deg - 9'd270;
    end else if (deg >= 9'd180) begin
      quad  = 2'd2;
      resid = deg - 9'd180;
    end else if (deg >= 9'd90) begin
      quad  = 2'd1;
      resid = deg - 9'd90;
    end else begin
      quad  = 2'd0;
      resid = deg;
    end
    word                    = '0;
    word[QUAD_MSB:QUAD_LSB] = quad;
    word[15:0]              = {7'b0, resid};
    return word;
  endfunction

endpackage

// File: rtl/cordic_valid_delay.sv
// cordic_valid_delay: DEPTH-stage 1-bit shift register with synchronous clear.
// Used to align side-band tags (sample valid, etc.) with the CORDIC pipeline.
//   clk  : clock
//   srst : synchronous active-high clear of every stage
//   din  : tag entering the pipeline
//   dout : tag delayed by exactly DEPTH cycles
module cordic_valid_delay #(
  parameter int DEPTH = 18
) (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  assign sr_d[0] = din;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
      assign sr_d[gi] = sr_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: phase accumulator and quadrant formatter feeding the
// pipelined CORDIC sin/cos core.
//   CLK_50M      : clock
//   RST          : synchronous active-high reset
//   Start        : IDLE -> RUN, loads Phase_Init (Q16.16 degrees)
//   Stop         : RUN -> DRAIN
//   En           : in RUN, emit one sample and advance by Freq_Word
//   Freq_Word    : phase step, Q16.16 degrees, must be < 360 deg
//   Phase_Init   : start phase, Q16.16 degrees, must be < 360 deg
//   Phase        : {14'b0, quadrant, residual degrees}
//   Phase_Valid  : Phase carries a new sample
//   Sample_Valid : Phase_Valid delayed by the core latency
//   Wrap         : this sample follows a 360-degree crossing
//   Busy         : in RUN or DRAIN
//   Cfg_Err      : sticky illegal step / init flag, cleared by Start
module cordic_phase_gen #(
  parameter int CORDIC_LAT = cordic_pkg::CORDIC_LAT,
  parameter int FRAC_W     = cordic_pkg::FRAC_W
) (
  input  logic        CLK_50M,
  input  logic        RST,
  input  logic        Start,
  input  logic        Stop,
  input  logic        En,
  input  logic [31:0] Freq_Word,
  input  logic [31:0] Phase_Init,
  output logic [31:0] Phase,
  output logic        Phase_Valid,
  output logic        Sample_Valid,
  output logic        Wrap,
  output logic        Busy,
  output logic        Cfg_Err
);

  import cordic_pkg::*;

  localparam int          ACC_W = FRAC_W + 9;
  localparam int          CNT_W = (CORDIC_LAT > 1) ? $clog2(CORDIC_LAT) : 1;
  localparam logic [31:0] LIM32 = 32'(360) << FRAC_W;
  localparam logic [ACC_W:0] LIM = LIM32[ACC_W:0];

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               wrap_pend_q, wrap_pend_d;
  logic               cfg_err_q, cfg_err_d;
  logic [31:0]        phase_q, phase_d;
  logic               phase_valid_q, phase_valid_d;
  logic               wrap_q, wrap_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;

  logic               step_ok;
  logic [ACC_W-1:0]   step;
  // One extra bit: acc + step can reach almost 720 degrees.
  logic [ACC_W:0]     sum;
  logic [ACC_W:0]     sum_wr;

  assign step_ok = (Freq_Word < LIM32);
  assign step    = step_ok ? Freq_Word[ACC_W-1:0] : '0;
  assign sum     = {1'b0, acc_q} + {1'b0, step};
  assign sum_wr  = sum - LIM;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    wrap_pend_d   = wrap_pend_q;
    cfg_err_d     = cfg_err_q;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    wrap_d        = 1'b0;
    drain_cnt_d   = drain_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d     = ST_RUN;
          wrap_pend_d = 1'b0;
          if (Phase_Init >= LIM32) begin
            acc_d     = '0;
            cfg_err_d = 1'b1;
          end else begin
            acc_d     = Phase_Init[ACC_W-1:0];
            cfg_err_d = 1'b0;
          end
        end
      end

      ST_RUN: begin
        if (Stop) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end else if (En) begin
          phase_valid_d = 1'b1;
          phase_d       = to_phase(acc_q[ACC_W-1:FRAC_W]);
          // A crossing is reported on the sample after the one that caused it.
          wrap_d        = wrap_pend_q;
          if (!step_ok) begin
            cfg_err_d = 1'b1;
          end
          if (sum >= LIM) begin
            acc_d       = sum_wr[ACC_W-1:0];
            wrap_pend_d = 1'b1;
          end else begin
            acc_d       = sum[ACC_W-1:0];
            wrap_pend_d = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        // Stay until the last in-flight sample has left the core.
        if (drain_cnt_q == CNT_W'(CORDIC_LAT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      wrap_pend_q   <= 1'b0;
      cfg_err_q     <= 1'b0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
      drain_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      wrap_pend_q   <= wrap_pend_d;
      cfg_err_q     <= cfg_err_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
      drain_cnt_q   <= drain_cnt_d;
    end
  end

  cordic_valid_delay #(
    .DEPTH (CORDIC_LAT)
  ) u_valid_delay (
    .clk  (CLK_50M),
    .srst (RST),
    .din  (phase_valid_q),
    .dout (Sample_Valid)
  );

  assign Phase       = phase_q;
  assign Phase_Valid = phase_valid_q;
  assign Wrap        = wrap_q;
  assign Cfg_Err     = cfg_err_q;
  assign Busy        = (state_q != ST_IDLE);

endmodule
